vid_timing_gen: RTL and testbench
=================================

VID_TIMING_GEN -- requirements
Module: vid_timing_gen

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the width of the pixel and line counters and of x/y.
REQ-002 Parameter H_ACTIVE, default 640, SHALL give the active pixels per line (>=1).
REQ-003 Parameter H_BLANK, default 16, SHALL give the blank cycles per line (>=1).
REQ-004 Parameter V_ACTIVE, default 480, SHALL give the active lines per frame (>=1).
REQ-005 Parameter V_BLANK, default 4, SHALL give the blank lines per frame (>=0).
REQ-006 clk  input  1  SHALL be the clock, with all logic on the rising edge.
REQ-007 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-008 en  input  1  SHALL request frame generation, sampled only in IDLE and on the last cycle of a frame.
REQ-009 hsync  output  1  SHALL be a one-cycle pulse on the last cycle of every line.
REQ-010 vsync  output  1  SHALL be a one-cycle pulse on the first cycle of every frame.
REQ-011 de  output  1  SHALL mark active pixels.
REQ-012 x  output  ADDR_W  SHALL carry the active pixel column.
REQ-013 y  output  ADDR_W  SHALL carry the active line.
REQ-014 busy  output  1  SHALL be high whenever the block is not in IDLE.
REQ-015 frame_done  output  1  SHALL be a one-cycle pulse on the last cycle of every frame.

Function
REQ-016 Definitions: L = H_ACTIVE+H_BLANK; VT = V_ACTIVE+V_BLANK; hcnt counts 0..L-1; vcnt counts 0..VT-1.
REQ-017 ADDR_W SHALL hold L-1 and VT-1; elaboration SHALL fail otherwise.
REQ-018 All outputs SHALL be registered and SHALL describe the (hcnt,vcnt) position of the current cycle.
REQ-019 FSM states: IDLE, ACTIVE (vcnt<V_ACTIVE, hcnt<H_ACTIVE), HBLANK (vcnt<V_ACTIVE, hcnt>=H_ACTIVE), VBLANK (vcnt>=V_ACTIVE).
REQ-020 IDLE: all outputs 0 and counters 0; en=1 at an edge SHALL start position (0,0) in ACTIVE on the next cycle.
REQ-021 hcnt SHALL increment every running cycle and wrap L-1 -> 0; vcnt SHALL increment on that wrap.
REQ-022 Transitions: ACTIVE->HBLANK when hcnt reaches H_ACTIVE; HBLANK->ACTIVE on line wrap if the next vcnt < V_ACTIVE; otherwise -> VBLANK.
REQ-023 de SHALL be 1 only in ACTIVE; x=hcnt and y=vcnt while de=1; x=y=0 while de=0.
REQ-024 hsync SHALL be 1 when hcnt==L-1 in any running state, including VBLANK lines.
REQ-025 vsync SHALL be 1 only when hcnt==0 and vcnt==0; hsync and vsync are never high together.
REQ-026 frame_done SHALL be 1 when hcnt==L-1 and vcnt==VT-1; it coincides with hsync.
REQ-027 On the frame_done cycle: en=1 -> next cycle at (0,0) with vsync and no gap; en=0 -> IDLE.
REQ-028 en deasserted mid-frame SHALL be ignored; the current frame SHALL complete.
REQ-029 V_BLANK=0: the last active line's wrap SHALL go directly to the next frame or to IDLE.
REQ-030 The hsync period SHALL be exactly L cycles, so a downstream line-width counter measures L-1.

Reset
REQ-031 rst=1 SHALL force IDLE and counters 0 on the next edge, with all outputs 0, overriding en and any state.
REQ-032 After rst falls, the block SHALL remain in IDLE until en=1 is sampled, then start at (0,0) with vsync.

Verification
Parameters H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, V_BLANK=1 (L=6, VT=4, 24-cycle frame); cycle 0 = first running cycle.
REQ-033 Reset: rst=1 with en=1 for 3 cycles -> hsync=vsync=de=busy=frame_done=0, x=y=0 throughout.
REQ-034 Start/line shape: en=1 from IDLE -> cycle 0 vsync=1, de=1, x=0, y=0; per-line de pattern 1,1,1,1,0,0; hsync at cycles 5,11,17,23; de=0 for cycles 18-23.
REQ-035 Back-to-back: en held high -> frame_done at cycle 23; cycle 24 vsync=1, x=0, y=0, busy stays 1.
REQ-036 Stop: en drops at cycle 10 -> frame completes, frame_done at 23, cycle 24 IDLE with busy=0 and all outputs 0.
REQ-037 Mid-frame reset: rst=1 at cycle 13 -> next cycle all outputs 0, busy=0; en=1 afterwards -> restart at (0,0) with vsync.
REQ-038 Width check: a counter reset by each hsync reads 5 at every hsync; with V_BLANK=0, frame_done falls at cycle 17.

Source files
------------

// File: rtl/vid_timing_gen.sv
// Purpose: raster timing generator producing de/x/y, hsync, vsync and frame_done for a
//          programmable active/blank geometry. All outputs are registered and reflect
//          the (hcnt,vcnt) position of the current cycle. Latency: en at an edge -> (0,0) next cycle.
// Backpressure: none. en is sampled only in IDLE and on the last cycle of a frame.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   en             frame request
//   hsync          one-cycle pulse on the last cycle of every line
//   vsync          one-cycle pulse on the first cycle of every frame
//   de, x, y       active-pixel strobe and its column/line (x=y=0 outside active video)
//   busy           high whenever not idle
//   frame_done     one-cycle pulse on the last cycle of every frame
module vid_timing_gen #(
  parameter int ADDR_W   = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 16,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              busy,
  output logic              frame_done
);

  localparam int L  = H_ACTIVE + H_BLANK;
  localparam int VT = V_ACTIVE + V_BLANK;

  // Geometry sanity: counters must be able to hold L-1 and VT-1.
  generate
    if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 || V_BLANK < 0) begin : g_bad_geometry
      $error("vid_timing_gen: illegal H_ACTIVE/H_BLANK/V_ACTIVE/V_BLANK");
    end
    if ((longint'(L) - 1) > ((longint'(1) << ADDR_W) - 1) ||
        (longint'(VT) - 1) > ((longint'(1) << ADDR_W) - 1)) begin : g_bad_width
      $error("vid_timing_gen: ADDR_W too small for L-1 or VT-1");
    end
  endgenerate

  // Compare constants are all "last index" values so they always fit in ADDR_W,
  // even when V_BLANK=0 makes V_ACTIVE equal to VT.
  localparam logic [ADDR_W-1:0] H_LAST     = ADDR_W'(L - 1);
  localparam logic [ADDR_W-1:0] V_LAST     = ADDR_W'(VT - 1);
  localparam logic [ADDR_W-1:0] H_ACT_LAST = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] V_ACT_LAST = ADDR_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] hcnt_q, hcnt_d;
  logic [ADDR_W-1:0] vcnt_q, vcnt_d;

  logic              line_end;
  logic              frame_end;

  // Output values for the position about to be entered.
  logic              run_d;
  logic              hsync_d;
  logic              vsync_d;
  logic              de_d;
  logic              frame_done_d;
  logic [ADDR_W-1:0] x_d;
  logic [ADDR_W-1:0] y_d;

  assign line_end  = (hcnt_q == H_LAST);
  assign frame_end = line_end && (vcnt_q == V_LAST);

  // Next-state and next-position logic.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;

    unique case (state_q)
      S_IDLE: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (en) begin
          state_d = S_ACTIVE;
        end
      end

      default: begin
        if (frame_end) begin
          // Back-to-back frames continue with no gap; otherwise park in IDLE.
          hcnt_d  = '0;
          vcnt_d  = '0;
          state_d = en ? S_ACTIVE : S_IDLE;
        end else if (line_end) begin
          hcnt_d = '0;
          vcnt_d = vcnt_q + ONE;
          // vcnt_q < V_ACTIVE-1 is the same as "next line is still active".
          state_d = (vcnt_q < V_ACT_LAST) ? S_ACTIVE : S_VBLANK;
        end else begin
          hcnt_d = hcnt_q + ONE;
          if (state_q == S_ACTIVE && hcnt_q == H_ACT_LAST) begin
            state_d = S_HBLANK;
          end
        end
      end
    endcase
  end

  // Outputs are derived from the next position and registered alongside it,
  // so each output describes the position the counters hold in the same cycle.
  always_comb begin
    run_d        = (state_d != S_IDLE);
    de_d         = (state_d == S_ACTIVE);
    hsync_d      = run_d && (hcnt_d == H_LAST);
    frame_done_d = hsync_d && (vcnt_d == V_LAST);
    vsync_d      = run_d && (hcnt_d == '0) && (vcnt_d == '0);
    x_d          = de_d ? hcnt_d : '0;
    y_d          = de_d ? vcnt_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
      de         <= 1'b0;
      x          <= '0;
      y          <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      de         <= de_d;
      x          <= x_d;
      y          <= y_d;
      busy       <= run_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: two instances (V_BLANK=1 and V_BLANK=0) share en/rst and are
// compared each cycle against a frame-index reference model; hsync spacing is measured too.
module tb_vid_timing_gen;

  localparam int AW = 11;
  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 3;
  localparam int LEN = HA + HB;

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          busy;
    logic          frame_done;
    logic [AW-1:0] x;
    logic [AW-1:0] y;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  logic          hs0, vs0, de0, busy0, fd0;
  logic [AW-1:0] x0, y0;
  logic          hs1, vs1, de1, busy1, fd1;
  logic [AW-1:0] x1, y1;

  always #5 clk = ~clk;

  vid_timing_gen #(.ADDR_W(AW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(1)) dut_vb1 (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
    .busy(busy0), .frame_done(fd0)
  );

  vid_timing_gen #(.ADDR_W(AW), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(0)) dut_vb0 (
    .clk(clk), .rst(rst), .en(en),
    .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
    .busy(busy1), .frame_done(fd1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_n    = 0;

  // Reference model: a frame is just a run of flen cycles numbered t = 0..flen-1.
  bit m_run [2];
  int m_t   [2];
  int flen  [2];
  int meas  [2];
  bit prev_hs [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
  endtask

  function automatic obs_t ref_out(input bit run, input int t, input int fl);
    obs_t o;
    int h, v;
    o = '0;
    if (run) begin
      h = t % LEN;
      v = t / LEN;
      o.busy       = 1'b1;
      o.hsync      = (h == LEN - 1);
      o.vsync      = (t == 0);
      o.frame_done = (t == fl - 1);
      o.de         = (h < HA) && (v < VA);
      if (o.de) begin
        o.x = AW'(h);
        o.y = AW'(v);
      end
    end
    return o;
  endfunction

  task automatic mstep(input int k, input bit e, input bit r);
    if (r) begin
      m_run[k] = 1'b0;
      m_t[k]   = 0;
    end else if (!m_run[k]) begin
      if (e) begin
        m_run[k] = 1'b1;
        m_t[k]   = 0;
      end
    end else if (m_t[k] == flen[k] - 1) begin
      m_t[k] = 0;
      if (!e) m_run[k] = 1'b0;
    end else begin
      m_t[k]++;
    end
  endtask

  task automatic compare(input int k, input obs_t got);
    obs_t  e;
    string p;
    e = ref_out(m_run[k], m_t[k], flen[k]);
    p = (k == 0) ? "vb1" : "vb0";
    chk({p, ".hsync"},      32'(got.hsync),      32'(e.hsync));
    chk({p, ".vsync"},      32'(got.vsync),      32'(e.vsync));
    chk({p, ".de"},         32'(got.de),         32'(e.de));
    chk({p, ".busy"},       32'(got.busy),       32'(e.busy));
    chk({p, ".frame_done"}, 32'(got.frame_done), 32'(e.frame_done));
    chk({p, ".x"},          32'(got.x),          32'(e.x));
    chk({p, ".y"},          32'(got.y),          32'(e.y));
    // Line-width counter: cleared at frame start and after each hsync.
    if (got.vsync === 1'b1 || prev_hs[k]) meas[k] = 0;
    else meas[k]++;
    if (got.hsync === 1'b1) chk({p, ".line_width"}, 32'(meas[k]), 32'(LEN - 1));
    prev_hs[k] = (got.hsync === 1'b1);
  endtask

  task automatic cyc(input bit e, input bit r);
    obs_t g0, g1;
    @(negedge clk);
    en  = e;
    rst = r;
    @(posedge clk);
    mstep(0, e, r);
    mstep(1, e, r);
    #1;
    cyc_n++;
    g0.hsync = hs0; g0.vsync = vs0; g0.de = de0; g0.busy = busy0; g0.frame_done = fd0;
    g0.x = x0; g0.y = y0;
    g1.hsync = hs1; g1.vsync = vs1; g1.de = de1; g1.busy = busy1; g1.frame_done = fd1;
    g1.x = x1; g1.y = y1;
    compare(0, g0);
    compare(1, g1);
  endtask

  initial begin
    int guard;
    flen[0] = LEN * (VA + 1);
    flen[1] = LEN * VA;
    for (int k = 0; k < 2; k++) begin
      m_run[k]   = 1'b0;
      m_t[k]     = 0;
      meas[k]    = 0;
      prev_hs[k] = 1'b0;
    end

    // Reset held with en high: everything stays quiet.
    repeat (3) cyc(1'b1, 1'b1);
    // Idle after reset release until en is seen.
    repeat (3) cyc(1'b0, 1'b0);

    // Start and run back-to-back frames.
    repeat (50) cyc(1'b1, 1'b0);

    // Drop en mid-frame: frame must complete and then go idle.
    guard = 0;
    while (!(m_run[0] && m_t[0] == 9) && guard < 100) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    repeat (20) cyc(1'b0, 1'b0);

    // Restart, then reset in the middle of a frame.
    guard = 0;
    while (!(m_run[0] && m_t[0] == 12) && guard < 100) begin
      cyc(1'b1, 1'b0);
      guard++;
    end
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    repeat (30) cyc(1'b1, 1'b0);

    // Randomized en with occasional resets.
    repeat (400) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);

    // Drain to idle.
    repeat (30) cyc(1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
